pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/load_use_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t          : controller FSM states (RUN, MEM_WAIT, HALTED)
//   MEM_WAIT_MAX_DEF : default memory-wait timeout in cycles
//   REG_ADDR_W       : register-address width of the pipeline
//   WAIT_CNT_W       : width of the memory-wait counter
// Optional feature macro used by the importing top: PIPE_HAZARD_CTRL_PERF_EN
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W       = 3;
    localparam int MEM_WAIT_MAX_DEF = 15;
    localparam int WAIT_CNT_W       = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    // Saturating increment for the memory-wait counter.
    function automatic logic [WAIT_CNT_W-1:0] sat_inc_cnt(input logic [WAIT_CNT_W-1:0] v);
        return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard check between the ID/EX load and the
// IF/ID source operands.
// Ports:
//   i_idex_mem_read : ID/EX instruction is a load
//   i_idex_rd       : ID/EX destination register
//   i_ifid_rs/rt    : IF/ID source registers
//   i_ifid_rs_vld   : rs is actually read
//   i_ifid_rt_vld   : rt is actually read
//   o_hazard        : load-use hazard present this cycle
// ----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rd,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    input  logic                  i_ifid_rs_vld,
    input  logic                  i_ifid_rt_vld,
    output logic                  o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_ifid_rs_vld && (i_ifid_rs == i_idex_rd);
    assign w_rt_match = i_ifid_rt_vld && (i_ifid_rt == i_idex_rd);
    assign o_hazard   = i_idex_mem_read && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for a 5-stage pipeline: load-use stalls, PC
// redirect flushes, data-memory wait with timeout, and halt freeze.
// Outputs are Mealy: decoded from the current state and current inputs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; load-use / redirect / memory stall decoded live
// MEM_WAIT | data memory busy; pipeline frozen until mem_done or timeout
// HALTED   | frozen after halt or memory timeout; left only by reset
//
// Ports:
//   clk, rst (sync, active-low)
//   idex_mem_read, idex_rd, ifid_rs, ifid_rt, ifid_rs_vld, ifid_rt_vld
//   branch_taken, jump, exmem_mem_en, mem_done, halt_mem
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en   : register load enables
//   ifid_flush, idex_flush, exmem_flush           : load bubble
//   mem_req, halted, mem_err
//   stall_cycles, flush_events, mem_wait_cycles   : only with
//                                                   PIPE_HAZARD_CTRL_PERF_EN
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_rs_vld,
    input  logic                  ifid_rt_vld,
    input  logic                  branch_taken,
    input  logic                  jump,
    input  logic                  exmem_mem_en,
    input  logic                  mem_done,
    input  logic                  halt_mem,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  mem_req,
    output logic                  halted,
    output logic                  mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_events,
    output logic [15:0]           mem_wait_cycles
`endif
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MEM_WAIT_MAX);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_mem_err;
    logic                  r_halted;
    logic                  r_lu_hold;

    state_t                w_nxt_state;
    logic [WAIT_CNT_W-1:0] w_nxt_cnt;
    logic                  w_set_err;
    logic                  w_hazard;
    logic                  w_redirect;
    logic                  w_run_dec;
    logic                  w_lu_taken;
    logic                  w_redir_taken;
    logic                  w_pc_en;
    logic                  w_ifid_en;
    logic                  w_idex_en;
    logic                  w_exmem_en;
    logic                  w_memwb_en;
    logic                  w_ifid_flush;
    logic                  w_idex_flush;
    logic                  w_exmem_flush;
    logic                  w_mem_req;

    load_use_detect u_load_use_detect (
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .i_ifid_rs       (ifid_rs),
        .i_ifid_rt       (ifid_rt),
        .i_ifid_rs_vld   (ifid_rs_vld),
        .i_ifid_rt_vld   (ifid_rt_vld),
        .o_hazard        (w_hazard)
    );

    assign w_redirect = branch_taken || jump;

    always_comb begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_mem_req     = 1'b0;
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_wait_cnt;
        w_set_err     = 1'b0;
        w_run_dec     = 1'b0;
        w_lu_taken    = 1'b0;
        w_redir_taken = 1'b0;

        if (!rst) begin
            // Reset holds every stage and fills the pipe with bubbles.
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_nxt_state   = RUN;
            w_nxt_cnt     = '0;
        end else if (halt_mem) begin
            // Halt outranks everything; any pending memory access is dropped.
            w_nxt_state = HALTED;
        end else begin
            case (r_state)
                RUN: begin
                    if (exmem_mem_en && !mem_done) begin
                        w_mem_req   = 1'b1;
                        w_nxt_state = MEM_WAIT;
                        // The RUN stall cycle counts as the first wait cycle.
                        w_nxt_cnt   = WAIT_CNT_W'(1);
                    end else begin
                        w_run_dec = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_done) begin
                        w_run_dec   = 1'b1;
                        w_nxt_state = RUN;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_mem_req = 1'b1;
                        w_nxt_cnt = sat_inc_cnt(r_wait_cnt);
                        if (r_wait_cnt >= MAX_CNT) begin
                            w_nxt_state = HALTED;
                            w_set_err   = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    w_nxt_state = HALTED;
                end
                default: begin
                    w_nxt_state = RUN;
                end
            endcase
        end

        if (w_run_dec) begin
            w_pc_en    = 1'b1;
            w_ifid_en  = 1'b1;
            w_idex_en  = 1'b1;
            w_exmem_en = 1'b1;
            w_memwb_en = 1'b1;
            w_mem_req  = exmem_mem_en;
            if (w_redirect) begin
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
                w_exmem_flush = 1'b1;
                w_redir_taken = 1'b1;
            end else if (w_hazard && !r_lu_hold) begin
                // r_lu_hold limits a load-use stall to a single cycle even if
                // the hazard inputs are still asserted the following cycle.
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
                w_lu_taken   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
            r_halted   <= 1'b0;
            r_lu_hold  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_wait_cnt <= w_nxt_cnt;
            r_mem_err  <= r_mem_err || w_set_err;
            r_halted   <= (w_nxt_state == HALTED);
            r_lu_hold  <= w_lu_taken;
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign idex_en     = w_idex_en;
    assign exmem_en    = w_exmem_en;
    assign memwb_en    = w_memwb_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_flush = w_exmem_flush;
    assign mem_req     = w_mem_req;
    assign halted      = r_halted;
    assign mem_err     = r_mem_err;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;
    logic [15:0] r_mem_wait_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles    <= '0;
            r_flush_events    <= '0;
            r_mem_wait_cycles <= '0;
        end else if (r_state != HALTED) begin
            if (w_lu_taken && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_redir_taken && (r_flush_events != 16'hFFFF))
                r_flush_events <= r_flush_events + 16'd1;
            if ((r_state == MEM_WAIT) && (r_mem_wait_cycles != 16'hFFFF))
                r_mem_wait_cycles <= r_mem_wait_cycles + 16'd1;
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign flush_events    = r_flush_events;
    assign mem_wait_cycles = r_mem_wait_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       idex_mem_read;
    logic [2:0] idex_rd;
    logic [2:0] ifid_rs;
    logic [2:0] ifid_rt;
    logic       ifid_rs_vld;
    logic       ifid_rt_vld;
    logic       branch_taken;
    logic       jump;
    logic       exmem_mem_en;
    logic       mem_done;
    logic       halt_mem;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic       mem_req, halted, mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      nm;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_rs_vld    (ifid_rs_vld),
        .ifid_rt_vld    (ifid_rt_vld),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .exmem_mem_en   (exmem_mem_en),
        .mem_done       (mem_done),
        .halt_mem       (halt_mem),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .mem_req        (mem_req),
        .halted         (halted),
        .mem_err        (mem_err)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events),
        .mem_wait_cycles(mem_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [4:0] E1 = 5'b11111;
    localparam logic [4:0] E0 = 5'b00000;
    localparam logic [4:0] LU = 5'b00111;

    // Expected word: {pc,ifid,idex,exmem,memwb en, ifid/idex/exmem flush, mem_req, halted, mem_err}
    function automatic logic [10:0] ex(input logic [4:0] en, input logic [2:0] fl,
                                       input logic mr, input logic h, input logic er);
        return {en, fl, mr, h, er};
    endfunction

    // One cycle of stimulus: drive just after the rising edge, push the
    // hand-computed response for the monitor to compare at the falling edge.
    task automatic v(input string nm, input bit chk, input logic r, input logic lr,
                     input logic [2:0] rd, input logic [2:0] rs, input logic rsv,
                     input logic [2:0] rt, input logic rtv, input logic br, input logic jp,
                     input logic me, input logic md, input logic hm, input logic [10:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        rst           = r;
        idex_mem_read = lr;
        idex_rd       = rd;
        ifid_rs       = rs;
        ifid_rs_vld   = rsv;
        ifid_rt       = rt;
        ifid_rt_vld   = rtv;
        branch_taken  = br;
        jump          = jp;
        exmem_mem_en  = me;
        mem_done      = md;
        halt_mem      = hm;
        if (chk) begin
            item.nm = nm;
            item.v  = e;
            exp_q.push_back(item);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        item;
            logic [10:0] act;
            item = exp_q.pop_front();
            act  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, mem_req, halted, mem_err};
            checks++;
            if (act !== item.v) begin
                failures++;
                $display("FAIL %s: got %b expected %b", item.nm, act, item.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; idex_mem_read = 1'b0; idex_rd = '0; ifid_rs = '0; ifid_rt = '0;
        ifid_rs_vld = 1'b0; ifid_rt_vld = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        exmem_mem_en = 1'b0; mem_done = 1'b0; halt_mem = 1'b0;

        //  name                 chk r  lr rd rs rsv rt rtv br jp me md hm  expected
        v("rst0",               0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E0, 3'b111, 0, 0, 0));
        v("rst_state",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E0, 3'b111, 0, 0, 0));
        v("idle",               1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("lu_rs",              1, 1, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, ex(LU, 3'b010, 0, 0, 0));
        v("lu_one_cycle",       1, 1, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("lu_rs_invalid",      1, 1, 1, 3, 3, 0, 5, 1, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("lu_rt",              1, 1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, ex(LU, 3'b010, 0, 0, 0));
        v("idle2",              1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("branch_over_lu",     1, 1, 1, 3, 3, 1, 0, 0, 1, 0, 0, 0, 0, ex(E1, 3'b111, 0, 0, 0));
        v("jump",               1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ex(E1, 3'b111, 0, 0, 0));
        v("mem_over_branch",    1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("mem_wait1",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("mem_wait2",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("mem_done",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ex(E1, 3'b000, 1, 0, 0));
        v("idle_after_mem",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("mem_same_cycle",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ex(E1, 3'b000, 1, 0, 0));
        v("idle3",              1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("to_stall",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("to_wait1",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("to_wait2",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("to_wait3",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("to_wait4",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("halted_err",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 0, 1, 1));
        v("halted_sticky",      1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, ex(E0, 3'b000, 0, 1, 1));
        v("rst_in_halted",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E0, 3'b111, 0, 1, 1));
        v("rst_release",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("halt_stall",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("halt_in_wait",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, ex(E0, 3'b000, 0, 0, 0));
        v("halted_after_halt",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E0, 3'b000, 0, 1, 0));
        v("rst2",               1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E0, 3'b111, 0, 1, 0));
        v("idle4",              1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("rst_stall",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b000, 1, 0, 0));
        v("rst_in_wait",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ex(E0, 3'b111, 0, 0, 0));
        v("no_residual_req",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E1, 3'b000, 0, 0, 0));
        v("halt_in_run",        1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, ex(E0, 3'b000, 0, 0, 0));
        v("halted_run",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(E0, 3'b000, 0, 1, 0));

        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
